// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding, default parameters and saturating helpers
package whack_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, OVER = 2'd3} state_t;
   localparam int DEF_SCORE_W     = 8;
   localparam int DEF_START_SCORE = 1;
   localparam int DEF_STREAK_STEP = 4;
   localparam int DEF_LEVEL_W     = 3;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? max : v + 32'd1;
   endfunction
   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction
endpackage

// File: rtl/whack_level_ctr.sv
// whack_level_ctr: consecutive-hit streak counter driving a saturating difficulty level
module whack_level_ctr import whack_pkg::*; #(
   parameter int STREAK_STEP = DEF_STREAK_STEP,
   parameter int LEVEL_W     = DEF_LEVEL_W
) (
   input  logic               systemClock,
   input  logic               reset,
   input  logic               clr,
   input  logic               hit_tick,
   input  logic               miss_tick,
   output logic [LEVEL_W-1:0] level
);
   localparam int SW = $clog2(STREAK_STEP + 1);
   localparam logic [31:0] LEVEL_MAX = (32'd1 << LEVEL_W) - 32'd1;
   localparam logic [SW-1:0] LAST = SW'(STREAK_STEP - 1);
   logic [SW-1:0] streak;
   // a full streak bumps the level and starts a new streak; a miss only drops the streak
   always_ff @(posedge systemClock or negedge reset) begin
      if (!reset) begin
         streak <= '0;
         level  <= '0;
      end else if (clr) begin
         streak <= '0;
         level  <= '0;
      end else if (hit_tick) begin
         streak <= (streak == LAST) ? '0 : streak + SW'(1);
         if (streak == LAST) level <= LEVEL_W'(sat_inc(32'(level), LEVEL_MAX));
      end else if (miss_tick) begin
         streak <= '0;
      end
   end
endmodule

// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: game FSM with saturating score, high score, level and game-over pulse
module whack_game_ctrl import whack_pkg::*; #(
   parameter int SCORE_W     = DEF_SCORE_W,
   parameter int START_SCORE = DEF_START_SCORE,
   parameter int STREAK_STEP = DEF_STREAK_STEP,
   parameter int LEVEL_W     = DEF_LEVEL_W
) (
   input  logic               systemClock,
   input  logic               reset,
   input  logic               startSwitch,
   input  logic               roundTick,
   input  logic               W,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] highScore,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         current_state,
   output logic               enable,
   output logic               gameOver
);
   localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
   localparam logic [SCORE_W-1:0] SCORE_INIT = SCORE_W'(START_SCORE);
   state_t state, state_nx;
   logic over_nx, live, hit_tick, miss_tick;
   // next state; a tick only counts while running with a nonzero score and the switch on
   always_comb begin
      state_nx = IDLE;
      over_nx  = 1'b0;
      live     = 1'b0;
      case (state)
         IDLE: state_nx = startSwitch ? LOAD : IDLE;
         LOAD: state_nx = RUN;
         RUN: begin
            state_nx = !startSwitch ? IDLE : (score == '0 ? OVER : RUN);
            over_nx  = startSwitch && score == '0;
            live     = startSwitch && score != '0;
         end
         OVER: state_nx = startSwitch ? OVER : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   assign hit_tick      = live & roundTick & W;
   assign miss_tick     = live & roundTick & ~W;
   assign enable        = state == RUN;
   assign current_state = state;
   // state register and registered game-over pulse
   always_ff @(posedge systemClock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         gameOver <= 1'b0;
      end else begin
         state    <= state_nx;
         gameOver <= over_nx;
      end
   end
   // score follows hits/misses; high score trails the running score by one cycle
   always_ff @(posedge systemClock or negedge reset) begin
      if (!reset) begin
         score     <= SCORE_INIT;
         highScore <= '0;
      end else begin
         if (state == LOAD) score <= SCORE_INIT;
         else if (hit_tick) score <= SCORE_W'(sat_inc(32'(score), SCORE_MAX));
         else if (miss_tick) score <= SCORE_W'(sat_dec(32'(score)));
         if (state == RUN && score > highScore) highScore <= score;
      end
   end
   whack_level_ctr #(.STREAK_STEP(STREAK_STEP), .LEVEL_W(LEVEL_W)) u_level (
      .systemClock(systemClock),
      .reset(reset),
      .clr(state == LOAD),
      .hit_tick(hit_tick),
      .miss_tick(miss_tick),
      .level(level)
   );
endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb_whack_game_ctrl: scenario tasks plus random play checked against a game-rules model
module tb_whack_game_ctrl;
   localparam int SW = 4, LW = 3, STEP = 4, START = 1, SMAX = 15, LMAX = 7;
   logic systemClock = 1'b0, reset = 1'b1, startSwitch = 1'b0, roundTick = 1'b0, W = 1'b0;
   logic [SW-1:0] score, highScore;
   logic [LW-1:0] level;
   logic [1:0] current_state;
   logic enable, gameOver;
   int checks = 0, failures = 0;
   int m_state, m_score, m_high, m_level, m_streak, m_go;

   always #5 systemClock = ~systemClock;

   whack_game_ctrl #(.SCORE_W(SW), .START_SCORE(START), .STREAK_STEP(STEP), .LEVEL_W(LW)) dut (
      .systemClock(systemClock), .reset(reset), .startSwitch(startSwitch), .roundTick(roundTick),
      .W(W), .score(score), .highScore(highScore), .level(level), .current_state(current_state),
      .enable(enable), .gameOver(gameOver)
   );

   function automatic logic [14:0] obs();
      return {score, highScore, level, current_state, enable, gameOver};
   endfunction
   function automatic logic [14:0] exp_v();
      return {4'(m_score), 4'(m_high), 3'(m_level), 2'(m_state), m_state == 2, m_go != 0};
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = START; m_high = 0; m_level = 0; m_streak = 0; m_go = 0;
   endtask

   // game rules: states 0 idle, 1 load, 2 run, 3 over; all decisions use pre-edge values
   task automatic model_step(input logic ss, input logic rt, input logic w);
      int s0, st0;
      s0 = m_score; st0 = m_state;
      m_go = (st0 == 2 && ss && s0 == 0) ? 1 : 0;
      if (st0 == 2 && s0 > m_high) m_high = s0;
      case (st0)
         0: if (ss) m_state = 1;
         1: begin m_state = 2; m_score = START; m_level = 0; m_streak = 0; end
         2: if (!ss) m_state = 0;
            else if (s0 == 0) m_state = 3;
            else if (rt && w) begin
               m_score = (s0 + 1 > SMAX) ? SMAX : s0 + 1;
               m_streak++;
               if (m_streak == STEP) begin
                  m_streak = 0;
                  m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
               end
            end else if (rt) begin
               m_score = s0 - 1; m_streak = 0;
            end
         default: if (!ss) m_state = 0;
      endcase
   endtask

   task automatic cycle(input logic ss, input logic rt, input logic w);
      startSwitch = ss; roundTick = rt; W = w;
      @(posedge systemClock);
      model_step(ss, rt, w);
      #1;
   endtask

   task automatic restart();
      cycle(0, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      model_reset();
      repeat (2) @(posedge systemClock);
      #1;
      checks++;
      if (obs() !== exp_v()) begin failures++; $display("FAIL reset_state got=%h want=%h", obs(), exp_v()); end
      checks++;
      if (score !== 4'd1 || highScore !== 4'd0) begin failures++; $display("FAIL reset_score got=%0d/%0d want=1/0", score, highScore); end
      reset = 1'b1;
   endtask

   task automatic test_start();
      cycle(1, 0, 0);
      checks++;
      if (current_state !== 2'd1 || enable !== 1'b0) begin failures++; $display("FAIL load_state got=%0d en=%b want=1 en=0", current_state, enable); end
      cycle(1, 1, 1);
      checks++;
      if (obs() !== exp_v()) begin failures++; $display("FAIL run_entry got=%h want=%h", obs(), exp_v()); end
      checks++;
      if (current_state !== 2'd2 || enable !== 1'b1 || score !== 4'd1 || level !== 3'd0) begin
         failures++; $display("FAIL run_values got st=%0d en=%b sc=%0d lv=%0d want 2 1 1 0", current_state, enable, score, level);
      end
   endtask

   task automatic test_hits();
      int want[4] = '{2, 3, 4, 3};
      for (int k = 0; k < 4; k++) begin
         cycle(1, 1, k < 3);
         checks++;
         if (score !== 4'(want[k]) || obs() !== exp_v()) begin failures++; $display("FAIL hits_score[%0d] got=%0d want=%0d", k, score, want[k]); end
      end
      cycle(1, 0, 0);
      checks++;
      if (highScore !== 4'd4 || level !== 3'd0 || obs() !== exp_v()) begin
         failures++; $display("FAIL hits_high got hs=%0d lv=%0d want hs=4 lv=0", highScore, level);
      end
   endtask

   task automatic test_saturate();
      restart();
      for (int k = 1; k <= 16; k++) begin
         cycle(1, 1, 1);
         checks++;
         if (score !== 4'((k + 1 > SMAX) ? SMAX : k + 1) || obs() !== exp_v()) begin
            failures++; $display("FAIL sat_score[%0d] got=%0d want=%0d", k, score, (k + 1 > SMAX) ? SMAX : k + 1);
         end
         if (k == 12 || k == 16) begin
            checks++;
            if (level !== 3'(k / 4)) begin failures++; $display("FAIL sat_level[%0d] got=%0d want=%0d", k, level, k / 4); end
         end
      end
   endtask

   task automatic test_game_over();
      restart();
      cycle(1, 1, 0);
      checks++;
      if (score !== 4'd0 || current_state !== 2'd2 || gameOver !== 1'b0) begin
         failures++; $display("FAIL over_drop got sc=%0d st=%0d go=%b want 0 2 0", score, current_state, gameOver);
      end
      cycle(1, 1, 1);
      checks++;
      if (current_state !== 2'd3 || gameOver !== 1'b1 || score !== 4'd0 || obs() !== exp_v()) begin
         failures++; $display("FAIL over_enter got st=%0d go=%b sc=%0d want 3 1 0", current_state, gameOver, score);
      end
      cycle(1, 1, 1);
      checks++;
      if (current_state !== 2'd3 || gameOver !== 1'b0 || score !== 4'd0) begin
         failures++; $display("FAIL over_pulse got st=%0d go=%b sc=%0d want 3 0 0", current_state, gameOver, score);
      end
      cycle(0, 0, 0);
      cycle(0, 1, 1);
      checks++;
      if (current_state !== 2'd0 || score !== 4'd0 || obs() !== exp_v()) begin
         failures++; $display("FAIL over_idle got st=%0d sc=%0d want 0 0", current_state, score);
      end
   endtask

   task automatic test_abort();
      restart();
      repeat (4) cycle(1, 1, 1);
      cycle(0, 0, 0);
      checks++;
      if (current_state !== 2'd0 || gameOver !== 1'b0 || score !== 4'd5 || obs() !== exp_v()) begin
         failures++; $display("FAIL abort got st=%0d go=%b sc=%0d want 0 0 5", current_state, gameOver, score);
      end
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      checks++;
      if (score !== 4'd1 || highScore !== 4'd15 || level !== 3'd0 || obs() !== exp_v()) begin
         failures++; $display("FAIL abort_restart got sc=%0d hs=%0d lv=%0d want 1 15 0", score, highScore, level);
      end
   endtask

   task automatic test_async_reset();
      cycle(1, 1, 1);
      cycle(1, 1, 1);
      roundTick = 1'b0;
      @(posedge systemClock);
      model_step(1, 0, 0);
      #3 reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs() !== exp_v() || highScore !== 4'd0 || current_state !== 2'd0) begin
         failures++; $display("FAIL async_reset got=%h want=%h", obs(), exp_v());
      end
      startSwitch = 1'b0;
      #2 reset = 1'b1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         checks++;
         if (obs() !== exp_v()) begin failures++; $display("FAIL random[%0d] got=%h want=%h", k, obs(), exp_v()); end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_hits();
      test_saturate();
      test_game_over();
      test_abort();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
